fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; 1-cycle arbitration, 0-cycle accept-to-write.
// Backpressure: fifo_full deasserts the owner's req_ready and stalls the burst without ending it.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, last_owner, pick;
  logic [BW-1:0]   beat_cnt;
  logic            xfer;
  logic            last_beat;

  // First valid requester strictly after the previous owner, wrapping to 0.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [OW-1:0]      last);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && vld[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick      = rr_pick(req_valid, last_owner);
  assign xfer      = (state == GRANT) && req_valid[owner] && !fifo_full;
  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|req_valid) state_nxt = GRANT;
      GRANT: begin
        // A stalled (full) cycle keeps the grant; only release or burst end leave it.
        if (!req_valid[owner])       state_nxt = IDLE;
        else if (xfer && last_beat)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = (state == GRANT);
    grant_id     = (state == GRANT) ? owner : last_owner;
    if (state == GRANT) req_ready[owner] = !fifo_full;
    if (xfer) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OW'(NUM_REQ - 1);
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else if (state == IDLE && |req_valid) begin
      owner      <= pick;
      last_owner <= pick;
      beat_cnt   <= '0;
    end else if (xfer) begin
      beat_cnt   <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus random traffic against a cycle-level reference of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // requester sources: words left, words sent, data base, voluntary hold-off
  int        src_cnt[NR];
  int        src_idx[NR];
  logic [7:0] src_base[NR];
  bit        hold[NR];

  // reference: who holds the port, who had it last, beats in this grant
  bit m_grant;
  int m_owner, m_last, m_beats;

  logic [7:0] dut_log[$];
  int         own_log[$];
  logic [7:0] fq[$];
  bit         fifo_mode;
  bit         drain;
  int         popped;
  int         exp_next[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (src_cnt[i] > 0) && !hold[i];
      req_data[i*DW +: DW]  = 8'(src_base[i] + 8'(src_idx[i]));
    end
    if (fifo_mode) fifo_full = (fq.size() >= 8);
  endtask

  task automatic cycle();
    bit         x;
    logic [7:0] d;
    bit         obs_en;
    logic [7:0] obs_d;
    int         sel;
    bit         found;
    logic [7:0] w;
    @(negedge clk);
    x = m_grant && req_valid[m_owner] && !fifo_full;
    d = x ? req_data[m_owner*DW +: DW] : 8'h00;
    chk("req_ready", 32'(req_ready), (m_grant && !fifo_full) ? (32'd1 << m_owner) : 32'd0);
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(x));
    chk("fifo_wr_data", 32'(fifo_wr_data), 32'(d));
    chk("grant_id", 32'(grant_id), 32'(m_grant ? m_owner : m_last));
    chk("busy", 32'(busy), 32'(m_grant));
    obs_en = fifo_wr_en;
    obs_d  = fifo_wr_data;
    if (obs_en) dut_log.push_back(obs_d);
    if (x) own_log.push_back(m_owner);
    @(posedge clk);
    if (!m_grant) begin
      if (req_valid != '0) begin
        found = 0;
        sel   = m_last;
        for (int k = 1; k <= NR; k++)
          if (!found && req_valid[(m_last + k) % NR]) begin
            sel   = (m_last + k) % NR;
            found = 1;
          end
        m_owner = sel;
        m_last  = sel;
        m_beats = 0;
        m_grant = 1;
      end
    end else if (!req_valid[m_owner]) begin
      m_grant = 0;
    end else if (x) begin
      src_cnt[m_owner]--;
      src_idx[m_owner]++;
      m_beats++;
      if (m_beats == MB) m_grant = 0;
    end
    if (fifo_mode) begin
      if (drain && fq.size() > 0) begin
        w = fq.pop_front();
        chk("drain_order", 32'(w[3:0]), 32'(exp_next[w[5:4]]));
        exp_next[w[5:4]]++;
        popped++;
      end
      if (obs_en) begin
        chk("no_overflow", 32'(fq.size() < 8), 32'd1);
        fq.push_back(obs_d);
      end
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_grant = 0; m_owner = NR - 1; m_last = NR - 1; m_beats = 0;
    for (int i = 0; i < NR; i++) begin
      src_cnt[i] = 0; src_idx[i] = 0; src_base[i] = 8'h00; hold[i] = 0; exp_next[i] = 0;
    end
    fifo_mode = 0; drain = 0; popped = 0; fifo_full = 1'b0;
    fq.delete(); dut_log.delete(); own_log.delete();
    drive();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'(NR - 1));
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [7:0] s1_exp[6];
    s1_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    req_valid = '0; req_data = '0; fifo_full = 1'b0; rst = 1'b1;

    // single requester: 4-beat burst, one idle cycle, re-grant for the rest
    do_reset();
    src_cnt[2] = 6; src_base[2] = 8'hA0; drive();
    t = 0;
    while (dut_log.size() < 6 && t < 60) begin cycle(); t++; end
    chk("s1_cycles", 32'(t), 32'd8);
    chk("s1_count", 32'(dut_log.size()), 32'd6);
    for (int j = 0; j < 6 && j < dut_log.size(); j++) chk("s1_data", 32'(dut_log[j]), 32'(s1_exp[j]));

    // round-robin, one word each
    do_reset();
    for (int i = 0; i < NR; i++) begin src_cnt[i] = 1; src_base[i] = 8'(i << 4); end
    drive();
    t = 0;
    while (own_log.size() < 4 && t < 60) begin cycle(); t++; end
    chk("s2_count", 32'(own_log.size()), 32'd4);
    for (int j = 0; j < 4 && j < own_log.size(); j++) chk("s2_order", 32'(own_log[j]), 32'(j));

    // all held valid: bursts of MB rotating and wrapping 3->0
    do_reset();
    for (int i = 0; i < NR; i++) begin src_cnt[i] = 100; src_base[i] = 8'(i << 4); end
    drive();
    t = 0;
    while (own_log.size() < 20 && t < 200) begin cycle(); t++; end
    chk("s2w_count", 32'(own_log.size()), 32'd20);
    for (int j = 0; j < 20 && j < own_log.size(); j++) chk("s2w_order", 32'(own_log[j]), 32'((j / MB) % NR));

    // full stall on requester 1's second beat
    do_reset();
    src_cnt[1] = 4; src_base[1] = 8'h40; drive();
    cycle(); cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("s3_held", 32'(grant_id), 32'd1);
    end
    fifo_full = 1'b0;
    t = 0;
    while (t < 12) begin cycle(); t++; end
    chk("s3_writes", 32'(dut_log.size()), 32'd4);

    // early release by 3, pending 0 granted next
    do_reset();
    src_cnt[3] = 2; src_base[3] = 8'h30; drive();
    cycle();
    src_cnt[0] = 1; src_base[0] = 8'h00; drive();
    t = 0;
    while (own_log.size() < 3 && t < 40) begin cycle(); t++; end
    chk("s4_count", 32'(own_log.size()), 32'd3);
    if (own_log.size() == 3) begin
      chk("s4_own0", 32'(own_log[0]), 32'd3);
      chk("s4_own1", 32'(own_log[1]), 32'd3);
      chk("s4_own2", 32'(own_log[2]), 32'd0);
    end

    // asynchronous reset mid-burst
    do_reset();
    src_cnt[2] = 4; src_base[2] = 8'h20; drive();
    t = 0;
    while (dut_log.size() < 2 && t < 40) begin cycle(); t++; end
    chk("s5_pre_wr_en", 32'(fifo_wr_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_abort_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("s5_abort_busy", 32'(busy), 32'd0);
    do_reset();
    src_cnt[0] = 1; src_cnt[2] = 1; src_base[2] = 8'h20; drive();
    t = 0;
    while (own_log.size() < 2 && t < 40) begin cycle(); t++; end
    chk("s5_count", 32'(own_log.size()), 32'd2);
    if (own_log.size() == 2) begin
      chk("s5_first", 32'(own_log[0]), 32'd0);
      chk("s5_second", 32'(own_log[1]), 32'd2);
    end

    // integration with a depth-8 FIFO: fill, then drain in order
    do_reset();
    fifo_mode = 1;
    for (int i = 0; i < NR; i++) begin src_cnt[i] = 8; src_base[i] = 8'(i << 4); end
    drive();
    t = 0;
    while (fq.size() < 8 && t < 200) begin cycle(); t++; end
    chk("s6_filled", 32'(fq.size()), 32'd8);
    for (int k = 0; k < 5; k++) cycle();
    chk("s6_no_more", 32'(dut_log.size()), 32'd8);
    drain = 1;
    t = 0;
    while ((popped < 32) && t < 400) begin cycle(); t++; end
    chk("s6_popped", 32'(popped), 32'd32);
    for (int i = 0; i < NR; i++) chk("s6_per_req", 32'(exp_next[i]), 32'd8);

    // random traffic, random holds, random fifo_full
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_cnt[i] == 0 && $urandom_range(0, 3) == 0) begin
          src_cnt[i]  = $urandom_range(1, 6);
          src_idx[i]  = 0;
          src_base[i] = 8'($urandom_range(0, 255));
        end
        hold[i] = ($urandom_range(0, 4) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      drive();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
